// File: rtl/vault_pkg.sv
// Shared types and default parameter values for the Infinite Vault sequencer.
package vault_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_RUN      = 3'd2,
    ST_FAILED   = 3'd3,
    ST_LOCKOUT  = 3'd4,
    ST_UNLOCKED = 3'd5
  } vault_state_e;

  localparam int DEF_NUM_PHASES     = 3;
  localparam int DEF_MAX_ATTEMPTS   = 3;
  localparam int DEF_LOCKOUT_CYCLES = 1000;
  localparam int DEF_PHASE_TIMEOUT  = 255;

endpackage

// File: rtl/vault_lockout_timer.sv
// Loadable counter: counts down (saturating at zero) or up, and flags when it
// holds EXPIRE_AT. Used for the lockout period and, optionally, the phase timeout.
module vault_lockout_timer #(
  parameter int WIDTH     = 10,
  parameter bit COUNT_UP  = 1'b0,
  parameter int EXPIRE_AT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             count_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i) begin
      if (COUNT_UP) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == WIDTH'(EXPIRE_AT));

endmodule

// File: rtl/vault_sequencer.sv
// Infinite Vault top-level sequencer: steps through the phase FSMs, counts failed
// attempts and enforces a timed lockout. Define VAULT_PHASE_TIMEOUT_EN to add a per-phase RUN timeout.
module vault_sequencer
  import vault_pkg::*;
#(
  parameter int NUM_PHASES     = DEF_NUM_PHASES,
  parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int PHASE_TIMEOUT  = DEF_PHASE_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              relock,
  input  logic [NUM_PHASES-1:0]             phase_done,
  input  logic [NUM_PHASES-1:0]             phase_fail,
  output logic [NUM_PHASES-1:0]             phase_rst,
  output logic [NUM_PHASES-1:0]             phase_en,
  output logic [$clog2(NUM_PHASES)-1:0]     cur_phase,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left,
  output logic                              busy,
  output logic                              unlocked,
  output logic                              locked_out
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  vault_state_e          state_q, state_d;
  logic [PW-1:0]         cur_q, cur_d;
  logic [AW-1:0]         att_q, att_d;
  logic [AW-1:0]         att_dec;
  logic [NUM_PHASES-1:0] cur_onehot;
  logic                  cur_done;
  logic                  cur_fail;
  logic                  lock_load;
  logic                  lock_expire;
  logic                  timeout_exp;

  assign cur_onehot = NUM_PHASES'(1) << cur_q;
  assign cur_done   = phase_done[cur_q];
  assign cur_fail   = phase_fail[cur_q];
  assign att_dec    = (att_q != '0) ? (att_q - AW'(1)) : '0;

  vault_lockout_timer #(
    .WIDTH     (LW),
    .COUNT_UP  (1'b0),
    .EXPIRE_AT (1)
  ) u_lockout_timer (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (lock_load),
    .load_val_i (LW'(LOCKOUT_CYCLES)),
    .count_i    (state_q == ST_LOCKOUT),
    .expire_o   (lock_expire)
  );

`ifdef VAULT_PHASE_TIMEOUT_EN
  localparam int TW = $clog2(PHASE_TIMEOUT + 1);

  // Expiring on PHASE_TIMEOUT-1 makes the PHASE_TIMEOUT-th RUN cycle the last one.
  vault_lockout_timer #(
    .WIDTH     (TW),
    .COUNT_UP  (1'b1),
    .EXPIRE_AT (PHASE_TIMEOUT - 1)
  ) u_phase_timer (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (state_q == ST_ARM),
    .load_val_i ('0),
    .count_i    (state_q == ST_RUN),
    .expire_o   (timeout_exp)
  );
`else
  assign timeout_exp = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    att_d     = att_q;
    lock_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cur_d = '0;
        if (!relock && start) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (relock) begin
          state_d = ST_IDLE;
          cur_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // relock beats the phase flags; fail beats done; both beat the timeout.
        if (relock) begin
          state_d = ST_IDLE;
          cur_d   = '0;
        end else if (cur_fail) begin
          state_d = ST_FAILED;
        end else if (cur_done) begin
          if (cur_q == PW'(NUM_PHASES - 1)) begin
            state_d = ST_UNLOCKED;
          end else begin
            state_d = ST_ARM;
            cur_d   = cur_q + PW'(1);
          end
        end else if (timeout_exp) begin
          state_d = ST_FAILED;
        end
      end
      ST_FAILED: begin
        att_d = att_dec;
        cur_d = '0;
        if (relock) begin
          state_d = ST_IDLE;
        end else if (att_dec == '0) begin
          state_d   = ST_LOCKOUT;
          lock_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (lock_expire) begin
          state_d = ST_IDLE;
          att_d   = AW'(MAX_ATTEMPTS);
        end
      end
      ST_UNLOCKED: begin
        if (relock) begin
          state_d = ST_IDLE;
          cur_d   = '0;
          att_d   = AW'(MAX_ATTEMPTS);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cur_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      att_q   <= AW'(MAX_ATTEMPTS);
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      att_q   <= att_d;
    end
  end

  always_comb begin
    phase_rst  = '1;
    phase_en   = '0;
    busy       = 1'b0;
    unlocked   = 1'b0;
    locked_out = 1'b0;
    case (state_q)
      ST_ARM, ST_FAILED: busy = 1'b1;
      ST_RUN: begin
        busy      = 1'b1;
        phase_en  = cur_onehot;
        phase_rst = ~cur_onehot;
      end
      ST_LOCKOUT:  locked_out = 1'b1;
      ST_UNLOCKED: unlocked   = 1'b1;
      default: ;
    endcase
  end

  assign cur_phase     = cur_q;
  assign attempts_left = att_q;

endmodule

// File: tb/tb_vault_sequencer.sv
// Self-checking bench for vault_sequencer: a reactive phase model drives done/fail,
// and expected latencies/counters come from the sequencing rules as plain arithmetic.
module tb_vault_sequencer;

  localparam int NP = 3;
  localparam int MA = 3;
  localparam int LC = 10;
  localparam int PT = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          relock;
  logic [NP-1:0] phase_done;
  logic [NP-1:0] phase_fail;
  logic [NP-1:0] phase_rst;
  logic [NP-1:0] phase_en;
  logic [1:0]    cur_phase;
  logic [1:0]    attempts_left;
  logic          busy;
  logic          unlocked;
  logic          locked_out;

  always #5 clk = ~clk;

  vault_sequencer #(
    .NUM_PHASES     (NP),
    .MAX_ATTEMPTS   (MA),
    .LOCKOUT_CYCLES (LC),
    .PHASE_TIMEOUT  (PT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .relock        (relock),
    .phase_done    (phase_done),
    .phase_fail    (phase_fail),
    .phase_rst     (phase_rst),
    .phase_en      (phase_en),
    .cur_phase     (cur_phase),
    .attempts_left (attempts_left),
    .busy          (busy),
    .unlocked      (unlocked),
    .locked_out    (locked_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_att;
  int plan_delay[NP];
  int plan_fail_ph;
  bit plan_both;
  bit plan_stray;
  int run_cnt;
  int last_idx;
  int en_order[$];
  int rst_fall[NP];
  bit multi_hot;
  logic [NP-1:0] prev_rst;
  logic [NP-1:0] prev_en;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if ($countones(phase_en) > 1) multi_hot = 1'b1;
    if (phase_en != '0 && phase_en != prev_en) begin
      for (int i = 0; i < NP; i++) if (phase_en[i]) en_order.push_back(i);
    end
    for (int i = 0; i < NP; i++) if (prev_rst[i] && !phase_rst[i]) rst_fall[i]++;
    prev_rst = phase_rst;
    prev_en  = phase_en;
  endtask

  // Behavioural phase FSMs: the active phase answers plan_delay cycles after its RUN starts.
  task automatic respond();
    int idx;
    idx = -1;
    phase_done = '0;
    phase_fail = '0;
    for (int i = 0; i < NP; i++) if (phase_en[i]) idx = i;
    if (idx < 0 || idx != last_idx) run_cnt = 0;
    else run_cnt++;
    last_idx = idx;
    if (idx >= 0) begin
      if (run_cnt == plan_delay[idx]) begin
        if (idx == plan_fail_ph) begin
          phase_fail[idx] = 1'b1;
          if (plan_both) phase_done[idx] = 1'b1;
        end else begin
          phase_done[idx] = 1'b1;
        end
      end
      if (plan_stray) begin
        for (int j = 0; j < NP; j++) begin
          if (j != idx) begin
            phase_done[j] = 1'b1;
            phase_fail[j] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic clear_tracking();
    en_order.delete();
    for (int i = 0; i < NP; i++) rst_fall[i] = 0;
    multi_hot = 1'b0;
    prev_rst  = phase_rst;
    prev_en   = phase_en;
    run_cnt   = 0;
    last_idx  = -1;
  endtask

  task automatic run_attempt(input int d0, input int d1, input int d2, input int fph,
                             input bit both, input bit stray, output int off, output bit unl);
    int t0;
    plan_delay[0] = d0;
    plan_delay[1] = d1;
    plan_delay[2] = d2;
    plan_fail_ph  = fph;
    plan_both     = both;
    plan_stray    = stray;
    clear_tracking();
    off = -1;
    unl = 1'b0;
    t0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      respond();
      step();
      if (unlocked) begin
        unl = 1'b1;
        off = cyc - t0;
        break;
      end
      if (!busy) begin
        off = cyc - t0;
        break;
      end
    end
    phase_done = '0;
    phase_fail = '0;
    if (off < 0) begin
      checks++;
      errors++;
      $display("FAIL attempt_bound: no unlock or return from busy within 300 cycles");
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    relock     = 1'b0;
    phase_done = '0;
    phase_fail = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (phase_rst !== 3'b111) begin errors++; $display("FAIL reset_phase_rst: got %b, expected 111", phase_rst); end
    checks++; if (phase_en !== 3'b000) begin errors++; $display("FAIL reset_phase_en: got %b, expected 000", phase_en); end
    checks++; if (cur_phase !== 2'd0) begin errors++; $display("FAIL reset_cur_phase: got %0d, expected 0", cur_phase); end
    checks++; if (attempts_left !== 2'(MA)) begin errors++; $display("FAIL reset_attempts: got %0d, expected %0d", attempts_left, MA); end
    checks++; if ({busy, unlocked, locked_out} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy/unl/lock %b, expected 000", {busy, unlocked, locked_out}); end
    reset_n = 1'b1;
    model_att = MA;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b, expected 0", busy); end
  endtask

  task automatic test_unlock(input int d0, input int d1, input int d2, input bit stray);
    int off;
    bit unl;
    int exp_off;
    exp_off = 1 + (d0 + 2) + (d1 + 2) + (d2 + 2);
    run_attempt(d0, d1, d2, -1, 1'b0, stray, off, unl);
    checks++; if (!unl || off != exp_off) begin errors++; $display("FAIL unlock_latency: got unlocked=%0d at %0d, expected unlocked at %0d (delays %0d %0d %0d)", unl, off, exp_off, d0, d1, d2); end
    checks++; if (en_order.size() != 3 || en_order[0] != 0 || en_order[1] != 1 || en_order[2] != 2) begin errors++; $display("FAIL phase_order: got %0d enables, expected order 0,1,2", en_order.size()); end
    checks++; if (rst_fall[0] != 1 || rst_fall[1] != 1 || rst_fall[2] != 1) begin errors++; $display("FAIL phase_rst_release: got %0d/%0d/%0d releases, expected 1 each", rst_fall[0], rst_fall[1], rst_fall[2]); end
    checks++; if (multi_hot) begin errors++; $display("FAIL phase_en_onehot: got multiple enables, expected at most one"); end
    checks++; if (phase_rst !== 3'b111 || phase_en !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL unlocked_outputs: got rst %b en %b busy %b, expected 111 000 0", phase_rst, phase_en, busy); end
    relock = 1'b1;
    step();
    relock = 1'b0;
    model_att = MA;
    checks++; if (unlocked !== 1'b0 || busy !== 1'b0 || cur_phase !== 2'd0) begin errors++; $display("FAIL relock_from_unlocked: got unl %b busy %b cur %0d, expected 0 0 0", unlocked, busy, cur_phase); end
    checks++; if (attempts_left !== 2'(model_att)) begin errors++; $display("FAIL unlock_attempts: got %0d, expected %0d", attempts_left, model_att); end
  endtask

  task automatic test_fail(input int fph, input bit both, input bit stray);
    int d[NP];
    int off;
    bit unl;
    int exp_off;
    for (int i = 0; i < NP; i++) d[i] = $urandom_range(0, 5);
    exp_off = 4 + d[fph];
    for (int i = 0; i < fph; i++) exp_off += d[i] + 2;
    run_attempt(d[0], d[1], d[2], fph, both, stray, off, unl);
    model_att--;
    checks++; if (unl || off != exp_off) begin errors++; $display("FAIL fail_latency: got unlocked=%0d idle at %0d, expected fail idle at %0d (phase %0d)", unl, off, exp_off, fph); end
    checks++; if (attempts_left !== 2'(model_att)) begin errors++; $display("FAIL fail_attempts: got %0d, expected %0d", attempts_left, model_att); end
    checks++; if (cur_phase !== 2'd0 || unlocked !== 1'b0) begin errors++; $display("FAIL fail_return: got cur %0d unl %b, expected 0 0", cur_phase, unlocked); end
    checks++; if (locked_out !== (model_att == 0)) begin errors++; $display("FAIL fail_lockout_flag: got %b, expected %0d", locked_out, model_att == 0); end
    checks++; if (en_order.size() != fph + 1) begin errors++; $display("FAIL fail_phases_run: got %0d, expected %0d", en_order.size(), fph + 1); end
  endtask

  task automatic test_relock();
    int seen;
    plan_delay[0] = 2;
    plan_delay[1] = 2;
    plan_delay[2] = 50;
    plan_fail_ph  = -1;
    plan_both     = 1'b0;
    plan_stray    = 1'b0;
    clear_tracking();
    seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      respond();
      step();
      if (phase_en == 3'b100) seen++;
      if (seen == 3) break;
    end
    checks++; if (seen != 3) begin errors++; $display("FAIL relock_reach_phase2: got %0d cycles in phase 2, expected 3", seen); end
    relock     = 1'b1;
    phase_done = 3'b100;
    phase_fail = 3'b000;
    step();
    relock     = 1'b0;
    phase_done = '0;
    checks++; if (busy !== 1'b0 || unlocked !== 1'b0 || phase_en !== 3'b000) begin errors++; $display("FAIL relock_run: got busy %b unl %b en %b, expected 0 0 000", busy, unlocked, phase_en); end
    checks++; if (cur_phase !== 2'd0 || phase_rst !== 3'b111) begin errors++; $display("FAIL relock_run_idle: got cur %0d rst %b, expected 0 111", cur_phase, phase_rst); end
    checks++; if (attempts_left !== 2'(model_att)) begin errors++; $display("FAIL relock_attempts: got %0d, expected %0d", attempts_left, model_att); end
    start  = 1'b1;
    relock = 1'b1;
    step();
    start  = 1'b0;
    relock = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL relock_over_start: busy got %b, expected 0", busy); end
  endtask

  task automatic test_lockout();
    int lo;
    test_fail($urandom_range(0, 2), 1'b0, 1'b0);
    lo = 1;
    for (int n = 0; n < 100; n++) begin
      start = (n == 3);
      step();
      if (!locked_out) break;
      lo++;
    end
    start = 1'b0;
    model_att = MA;
    checks++; if (lo != LC) begin errors++; $display("FAIL lockout_length: got %0d cycles, expected %0d", lo, LC); end
    checks++; if (attempts_left !== 2'(model_att) || busy !== 1'b0) begin errors++; $display("FAIL lockout_exit: got attempts %0d busy %b, expected %0d 0", attempts_left, busy, model_att); end
    step();
    checks++; if (busy !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL lockout_start_ignored: got busy %b lock %b, expected 0 0", busy, locked_out); end
  endtask

  task automatic test_reset_mid_lockout();
    while (model_att > 0) test_fail($urandom_range(0, 2), 1'b0, 1'b0);
    repeat (3) step();
    checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL mid_lockout: locked_out got %b, expected 1", locked_out); end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (locked_out !== 1'b0 || busy !== 1'b0 || unlocked !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got lock %b busy %b unl %b, expected 0 0 0", locked_out, busy, unlocked); end
    checks++; if (attempts_left !== 2'(MA) || cur_phase !== 2'd0) begin errors++; $display("FAIL async_reset_counters: got attempts %0d cur %0d, expected %0d 0", attempts_left, cur_phase, MA); end
    checks++; if (phase_rst !== 3'b111 || phase_en !== 3'b000) begin errors++; $display("FAIL async_reset_phase: got rst %b en %b, expected 111 000", phase_rst, phase_en); end
    #1;
    reset_n = 1'b1;
    model_att = MA;
    step();
    checks++; if (locked_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL after_reset_idle: got lock %b busy %b, expected 0 0", locked_out, busy); end
  endtask

`ifdef VAULT_PHASE_TIMEOUT_EN
  task automatic test_timeout();
    int off;
    bit unl;
    run_attempt(1000, 1000, 1000, -1, 1'b0, 1'b0, off, unl);
    model_att--;
    checks++; if (unl || off != PT + 3) begin errors++; $display("FAIL timeout_latency: got idle at %0d, expected %0d", off, PT + 3); end
    checks++; if (attempts_left !== 2'(model_att)) begin errors++; $display("FAIL timeout_attempts: got %0d, expected %0d", attempts_left, model_att); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unlock(3, 3, 3, 1'b0);
    repeat (3) test_unlock($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1'b0);
    test_unlock($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1'b1);
    test_fail(1, 1'b0, 1'b0);
    test_fail(0, 1'b1, 1'b1);
    test_relock();
    test_lockout();
    test_reset_mid_lockout();
`ifdef VAULT_PHASE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vault_sequencer.md
# vault_sequencer

Top-level controller for the Infinite Vault. It sequences the per-phase code FSMs in order: it resets each phase, routes the code stream to it, and waits for that phase's done or fail. It also counts failed attempts and enforces a timed lockout. It sits above the phase FSMs and drives their active-high resets, so no phase FSM needs a self-exit from DONE/FAIL.

## Interface
Parameters:
- NUM_PHASES, 3, number of phase FSMs sequenced in order 0..NUM_PHASES-1
- MAX_ATTEMPTS, 3, failed attempts allowed before lockout (≥1)
- LOCKOUT_CYCLES, 1000, clock cycles spent in lockout (≥1)
- PHASE_TIMEOUT, 255, maximum RUN cycles per phase when the timeout is compiled in (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin an attempt; sampled only in IDLE
- relock  in  1  return to IDLE; ignored in LOCKOUT
- phase_done  in  NUM_PHASES  done flag from each phase FSM
- phase_fail  in  NUM_PHASES  fail flag from each phase FSM
- phase_rst  out  NUM_PHASES  active-high reset to each phase FSM
- phase_en  out  NUM_PHASES  one-hot; gates code_in to the current phase
- cur_phase  out  $clog2(NUM_PHASES)  index of the current phase
- attempts_left  out  $clog2(MAX_ATTEMPTS+1)  remaining attempts
- busy  out  1  high in ARM, RUN and FAILED
- unlocked  out  1  high in UNLOCKED
- locked_out  out  1  high in LOCKOUT

## Operation
All outputs are Moore outputs decoded from registered state and counters.

States:
- IDLE: phase_rst = all ones, phase_en = 0.
  - start → ARM with cur_phase = 0.
- ARM: phase_rst[cur_phase] = 1 for one cycle; all other phases are also held in reset.
  - Clears the timeout counter.
  - → RUN unconditionally.
- RUN: phase_en[cur_phase] = 1; phase_rst = 0 for the current phase and 1 for all others.
  - Only phase_done/phase_fail[cur_phase] are examined; flags from other phases are ignored.
  - Fail has priority: phase_fail[cur_phase] → FAILED.
  - Otherwise phase_done[cur_phase]: if cur_phase == NUM_PHASES-1 → UNLOCKED; else cur_phase+1 → ARM.
- FAILED: one cycle; attempts_left decrements.
  - If the decremented value is 0 → LOCKOUT and the lockout counter loads LOCKOUT_CYCLES.
  - Otherwise → IDLE.
- LOCKOUT: the counter decrements each cycle.
  - On the cycle it reads 1 → IDLE, and attempts_left reloads MAX_ATTEMPTS.
  - start and relock are ignored.
- UNLOCKED: phase_rst = all ones.
  - Holds until relock → IDLE, with attempts_left reloading MAX_ATTEMPTS.

relock while in ARM, RUN or FAILED:
- → IDLE, cur_phase = 0.
- No attempt is charged, except in FAILED, where the decrement already taken stands.

Reset values (reset_n low):
- State IDLE, cur_phase 0, attempts_left MAX_ATTEMPTS, counters 0.
- phase_rst all ones; phase_en, busy, unlocked and locked_out all 0.

Reset asserted mid-operation aborts immediately, including during LOCKOUT; attempts_left refills.

Simultaneous events:
- relock has priority over start in IDLE.
- relock has priority over done/fail in RUN.

## Timing
- Cycle t = start sampled in IDLE.
  - ARM occupies t+1; phase_rst[0] pulses high for exactly one cycle.
  - RUN begins at t+2.
- Done sampled in RUN at cycle k → ARM for the next phase at k+1, RUN at k+2.
  - Per-phase overhead is 2 cycles.
- Final done at cycle k → unlocked high from k+1.
- Fail at cycle k → FAILED at k+1.
  - attempts_left shows the decremented value from k+2.
  - locked_out goes high at k+2 when the decremented value is 0.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles; IDLE follows.

## Configuration
- VAULT_PHASE_TIMEOUT_EN defined:
  - A counter of $clog2(PHASE_TIMEOUT+1) bits increments each RUN cycle.
  - Reaching PHASE_TIMEOUT with no done or fail → FAILED, treated identically to phase_fail.
  - Done or fail on the same cycle takes priority over the timeout.
- Undefined: no counter exists, and RUN waits indefinitely.

## Structure
- Package vault_pkg contains:
  - the state enum type (IDLE, ARM, RUN, FAILED, LOCKOUT, UNLOCKED)
  - default parameter constants
- Sub-module vault_lockout_timer: a loadable down-counter with load, count and expire ports, used for LOCKOUT. When VAULT_PHASE_TIMEOUT_EN is defined, a second instance configured as an up-count is used for the phase timeout.

## Test plan
- Three phases each report done 3 cycles after entering RUN → unlocked high 16 cycles after start. Each phase_rst[i] pulses once; phase_en is strictly one-hot and in order 0, 1, 2.
- Phase 1 reports fail → FAILED, then IDLE; attempts_left goes 3→2; cur_phase returns to 0; unlocked stays 0.
- Three consecutive fails with LOCKOUT_CYCLES = 10 → locked_out high for exactly 10 cycles; start pulsed during lockout is ignored; attempts_left ends at 3.
- done and fail asserted together on the current phase, and a done asserted on a non-current phase → FAILED is taken, and the stray done is ignored.
- relock asserted during RUN of phase 2 → IDLE on the next cycle, attempts_left unchanged. reset_n dropped mid-LOCKOUT → all outputs return to their reset values immediately.
- With VAULT_PHASE_TIMEOUT_EN and PHASE_TIMEOUT = 8, phase 0 gives no response → FAILED entered on the 9th cycle after entering RUN.
